// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory and its neighbours.
// Widths here match the control unit and the instruction register.
package imem_pkg;

  localparam int          IMEM_DATA_W = 32;
  localparam int          IMEM_ADDR_W = 16;
  localparam int          IMEM_DEPTH  = 256;
  localparam logic [31:0] IMEM_NOP    = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Instruction storage: one sync read port, one sync write port.
// Ports: clk, rst_n, rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data.
module imem_ram_1r1w
  import imem_pkg::*;
#(
  parameter int    DATA_W    = IMEM_DATA_W,
  parameter int    DEPTH     = IMEM_DEPTH,
  parameter int    AW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself is never reset so a loaded image survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only updates on a read, so it doubles as the
  // held response while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_banked_fetch.sv
// Instruction memory with fetch handshake, NOP on bad address, and loader.
// Ports: req_*/rsp_* fetch path, prog_* streaming load, load_busy/load_err.
module imem_banked_fetch
  import imem_pkg::*;
#(
  parameter int                DATA_W    = IMEM_DATA_W,
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter int                DEPTH     = IMEM_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(IMEM_NOP),
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              load_busy,
  output logic              load_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  imem_state_t       state_q;
  imem_state_t       state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic              load_err_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] ram_q;
  logic              req_in;
  logic              ptr_in;
  logic              accept;
  logic              beat;
  logic              wr_en;

  assign req_in = {1'b0, req_addr} < DEPTH_L;
  assign ptr_in = {1'b0, ptr_q} < DEPTH_L;
  assign accept = req_valid && req_ready;
  // A restart in the same cycle as a beat wins; the beat is dropped.
  assign beat   = (state_q == ST_LOAD) && prog_valid && !prog_start;
  assign wr_en  = beat && ptr_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (prog_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (prog_start) begin
          state_d = ST_LOAD;
        end else if (prog_valid && prog_last) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // rst_n gates ready so nothing is accepted while held in reset.
  always_comb begin
    load_busy = (state_q == ST_LOAD);
    req_ready = rst_n && (state_q == ST_RUN) && !prog_start
             && (!rsp_valid_q || rsp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      load_err_q <= 1'b0;
    end else if (prog_start) begin
      ptr_q      <= prog_base;
      load_err_q <= 1'b0;
    end else if (beat) begin
      ptr_q <= ptr_q + 1'b1;
      if (!ptr_in) load_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !req_in;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  imem_ram_1r1w #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en  (accept && req_in),
    .rd_addr(req_addr[AW-1:0]),
    .rd_data(ram_q),
    .wr_en  (wr_en),
    .wr_addr(ptr_q[AW-1:0]),
    .wr_data(prog_data)
  );

  // Out-of-range fetches skip the read and substitute the NOP here.
  assign rsp_data  = rsp_err_q ? NOP_WORD : ram_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_banked_fetch.sv
// Self-checking bench for imem_banked_fetch: fetch table, backpressure,
// streaming load, overflow and reset-during-load sequences.
module tb_imem_banked_fetch;
  import imem_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        prog_start = 1'b0;
  logic [15:0] prog_base = '0;
  logic        prog_valid = 1'b0;
  logic [31:0] prog_data = '0;
  logic        prog_last = 1'b0;
  logic        load_busy;
  logic        load_err;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mdl [256];
  logic [31:0] q_d [$];
  logic        q_e [$];
  logic [31:0] ld_words [8];
  vec_t        tv [7];

  always #5 clk = ~clk;

  imem_banked_fetch #(
    .DATA_W   (32),
    .ADDR_W   (16),
    .DEPTH    (256),
    .NOP_WORD (32'h0000_0000),
    .INIT_FILE("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .prog_start(prog_start),
    .prog_base (prog_base),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_last (prog_last),
    .load_busy (load_busy),
    .load_err  (load_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wv(input int i);
    return (i == 3) ? 32'h4108_0005 : 32'h1000_0000 + 32'(i);
  endfunction

  // Scoreboard consumer: every response handshake pops one expectation.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q_d.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got data %h, required no response",
                 rsp_data);
      end else begin
        chk("rsp_data", rsp_data, q_d.pop_front());
        chkb("rsp_err", rsp_err, q_e.pop_front());
      end
    end
  end

  task automatic fetch(input logic [15:0] a, input logic [31:0] ed,
                       input logic ee);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    #4;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      #4;
      t++;
    end
    n_chk++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: addr %h not accepted, required within 20 cycles", a);
    end else begin
      q_d.push_back(ed);
      q_e.push_back(ee);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid  = 1'b0;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Streams n words from ld_words; updates the reference model as it goes.
  task automatic load(input logic [15:0] base, input int n,
                      input bit last, input bit fetch_try);
    logic [15:0] p = base;
    logic        lerr_exp = 1'b0;
    int          busy = 0;
    @(negedge clk);
    prog_start = 1'b1;
    prog_base  = base;
    if (fetch_try) begin
      req_valid = 1'b1;
      req_addr  = 16'd0;
    end
    #1 chkb("rdy_on_start", req_ready, 1'b0);
    @(negedge clk);
    prog_start = 1'b0;
    if (load_busy) busy++;
    #1;
    chkb("lerr_cleared", load_err, 1'b0);
    chkb("rdy_in_load", req_ready, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prog_valid = 1'b1;
      prog_data  = ld_words[i];
      prog_last  = last && (i == n - 1);
      if (load_busy) busy++;
      if (p < 16'd256) mdl[p[7:0]] = ld_words[i];
      else lerr_exp = 1'b1;
      p = p + 16'd1;
      #1 chkb("rdy_in_load", req_ready, 1'b0);
    end
    if (last) begin
      @(negedge clk);
      prog_valid = 1'b0;
      prog_last  = 1'b0;
      req_valid  = 1'b0;
      #1;
      chkb("busy_fall", load_busy, 1'b0);
      chk("busy_cycles", 32'(busy), 32'(n + 1));
      chkb("load_err", load_err, lerr_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{16'd3,     32'h4108_0005, 1'b0};
    tv[1] = '{16'd0,     32'h1000_0000, 1'b0};
    tv[2] = '{16'h0100,  32'h0000_0000, 1'b1};
    tv[3] = '{16'd0,     32'h1000_0000, 1'b0};
    tv[4] = '{16'hFFFF,  32'h0000_0000, 1'b1};
    tv[5] = '{16'd7,     32'h1000_0007, 1'b0};
    tv[6] = '{16'd1,     32'h1000_0001, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    chkb("rst_req_ready", req_ready, 1'b0);
    chkb("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chkb("rst_rsp_err", rsp_err, 1'b0);
    chkb("rst_load_busy", load_busy, 1'b0);
    chkb("rst_load_err", load_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chkb("post_rst_ready", req_ready, 1'b1);

    for (int i = 0; i < 8; i++) ld_words[i] = wv(i);
    load(16'd0, 8, 1'b1, 1'b0);

    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) fetch(tv[i].addr, tv[i].data, tv[i].err);
    idle(3);

    rsp_ready = 1'b0;
    fetch(16'd1, mdl[1], 1'b0);
    @(negedge clk);
    req_addr = 16'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chkb("bp_ready", req_ready, 1'b0);
      chkb("bp_valid", rsp_valid, 1'b1);
      chk("bp_hold", rsp_data, 32'h1000_0001);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #4;
    chkb("bp_accept2", req_ready, 1'b1);
    if (req_ready) begin
      q_d.push_back(mdl[2]);
      q_e.push_back(1'b0);
    end
    idle(3);
    chkb("rsp_cleared", rsp_valid, 1'b0);

    ld_words[0] = 32'hA;
    ld_words[1] = 32'hB;
    ld_words[2] = 32'hC;
    load(16'd8, 3, 1'b1, 1'b1);
    fetch(16'd8,  32'hA, 1'b0);
    fetch(16'd9,  32'hB, 1'b0);
    fetch(16'd10, 32'hC, 1'b0);
    idle(3);

    for (int i = 0; i < 4; i++) ld_words[i] = 32'hDEAD_0001 + 32'(i);
    load(16'd254, 4, 1'b1, 1'b0);
    chkb("ovf_err_set", load_err, 1'b1);
    fetch(16'd254, 32'hDEAD_0001, 1'b0);
    fetch(16'd255, 32'hDEAD_0002, 1'b0);
    fetch(16'd0,   32'h1000_0000, 1'b0);
    idle(3);

    rsp_ready = 1'b0;
    fetch(16'd5, mdl[5], 1'b0);
    idle(1);
    ld_words[0] = 32'h5555_0014;
    ld_words[1] = 32'h5555_0015;
    load(16'd20, 2, 1'b0, 1'b0);
    chkb("pend_valid", rsp_valid, 1'b1);
    chk("pend_data", rsp_data, 32'h1000_0005);
    @(negedge clk);
    prog_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chkb("mid_rst_busy", load_busy, 1'b0);
    chkb("mid_rst_valid", rsp_valid, 1'b0);
    chkb("mid_rst_ready", req_ready, 1'b0);
    q_d.delete();
    q_e.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    fetch(16'd20, 32'h5555_0014, 1'b0);
    fetch(16'd21, 32'h5555_0015, 1'b0);
    fetch(16'd5,  32'h1000_0005, 1'b0);
    idle(4);
    chk("sb_drained", 32'(q_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
